// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues imem reads and buffers
// returned words with their PCs in a DEPTH-entry FIFO for decode.
module fetch_queue_unit #(
  parameter int                WORD_W  = 32,
  parameter logic [WORD_W-1:0] PC_INIT = '0,
  parameter int                DEPTH   = 4
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       ihit,
  input  logic [WORD_W-1:0]          imemload,
  output logic                       imemREN,
  output logic [WORD_W-1:0]          imemaddr,
  input  logic                       redirect,
  input  logic [WORD_W-1:0]          redirect_pc,
  input  logic                       halt,
  input  logic                       deq,
  output logic                       valid,
  output logic [WORD_W-1:0]          instr,
  output logic [WORD_W-1:0]          instr_pc,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       halted
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  // A malformed DEPTH leaves the unit permanently idle rather than fetching
  // into a queue whose pointers cannot wrap correctly.
  localparam bit CFG_OK = (DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0);

  logic [WORD_W-1:0] fetch_pc;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [WORD_W-1:0] mem_instr [DEPTH];
  logic [WORD_W-1:0] mem_pc    [DEPTH];
  logic              push;
  logic              pop;

  assign imemREN  = CFG_OK && !halted && !redirect && (count < CNT_W'(DEPTH));
  assign imemaddr = fetch_pc;
  assign push     = imemREN && ihit;
  assign pop      = deq && valid && !redirect;

  assign valid    = (count != '0);
  assign instr    = valid ? mem_instr[rd_ptr] : '0;
  assign instr_pc = valid ? mem_pc[rd_ptr]    : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fetch_pc <= PC_INIT;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      halted   <= 1'b0;
    end else begin
      halted <= halted | halt;
      if (redirect) begin
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        fetch_pc <= {redirect_pc[WORD_W-1:2], 2'b00};
      end else begin
        if (push) begin
          wr_ptr   <= wr_ptr + PTR_W'(1);
          fetch_pc <= fetch_pc + WORD_W'(4);
        end
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // NOTE: the storage array has no reset; count gates valid/instr, so stale
  // entries are never visible and the array can map onto plain flops or RAM.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_instr[wr_ptr] <= imemload;
      mem_pc[wr_ptr]    <= fetch_pc;
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Scoreboard bench for fetch_queue_unit: directed scenarios plus randomized
// traffic checked against an occupancy/PC model and a queue of expected entries.
module tb_fetch_queue_unit;

  localparam int DEPTH  = 4;
  localparam int WORD_W = 32;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              CLK = 1'b0;
  logic              nRST = 1'b0;
  logic              ihit = 1'b0;
  logic [31:0]       imemload = '0;
  logic              imemREN;
  logic [31:0]       imemaddr;
  logic              redirect = 1'b0;
  logic [31:0]       redirect_pc = '0;
  logic              halt = 1'b0;
  logic              deq = 1'b0;
  logic              valid;
  logic [31:0]       instr;
  logic [31:0]       instr_pc;
  logic [CNT_W-1:0]  count;
  logic              halted;

  logic              ihit2 = 1'b0;
  logic [31:0]       imemload2 = '0;
  logic              deq2 = 1'b0;
  logic              imemREN2;
  logic [31:0]       imemaddr2;
  logic              valid2;
  logic [31:0]       instr2;
  logic [31:0]       instr_pc2;
  logic [CNT_W-1:0]  count2;
  logic              halted2;

  fetch_queue_unit #(.WORD_W(WORD_W), .PC_INIT(32'h0), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
    .imemREN(imemREN), .imemaddr(imemaddr), .redirect(redirect),
    .redirect_pc(redirect_pc), .halt(halt), .deq(deq), .valid(valid),
    .instr(instr), .instr_pc(instr_pc), .count(count), .halted(halted)
  );

  fetch_queue_unit #(.WORD_W(WORD_W), .PC_INIT(32'hFFFF_FFFC), .DEPTH(DEPTH)) dut_wrap (
    .CLK(CLK), .nRST(nRST), .ihit(ihit2), .imemload(imemload2),
    .imemREN(imemREN2), .imemaddr(imemaddr2), .redirect(1'b0),
    .redirect_pc(32'h0), .halt(1'b0), .deq(deq2), .valid(valid2),
    .instr(instr2), .instr_pc(instr_pc2), .count(count2), .halted(halted2)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: occupancy, fetch PC and halt flag, plus expected entries.
  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } entry_t;

  entry_t      sb_q[$];
  int          m_cnt = 0;
  logic [31:0] m_pc = 32'h0;
  bit          m_halted = 0;

  bit          exp_fresh = 0;
  int          exp_count;
  bit          exp_ren;
  logic [31:0] exp_addr;
  bit          exp_halted;

  task automatic step(input bit ih, input logic [31:0] ld, input bit dq,
                      input bit rd, input logic [31:0] rpc, input bit hl);
    bit p_push, p_pop;
    @(negedge CLK);
    nRST = 1'b1;
    ihit = ih; imemload = ld; deq = dq; redirect = rd; redirect_pc = rpc; halt = hl;
    exp_count  = m_cnt;
    exp_ren    = !m_halted && !rd && (m_cnt < DEPTH);
    exp_addr   = m_pc;
    exp_halted = m_halted;
    exp_fresh  = 1;
    p_push = exp_ren && ih;
    p_pop  = dq && (m_cnt > 0) && !rd;
    if (rd) begin
      m_cnt = 0;
      m_pc  = {rpc[31:2], 2'b00};
    end else begin
      if (p_push) begin
        sb_q.push_back('{word: ld, pc: m_pc});
        m_pc = m_pc + 32'd4;
      end
      m_cnt = m_cnt + int'(p_push) - int'(p_pop);
    end
    if (hl) m_halted = 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, 0, '0, 0);
  endtask

  // Asserts reset between clock edges and checks the flush is immediate.
  task automatic async_reset();
    @(negedge CLK);
    #3 nRST = 1'b0;
    ihit = 0; deq = 0; redirect = 0; halt = 0;
    #1;
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_valid", 32'(valid), 32'd0);
    check("async_rst_instr", instr, 32'h0);
    check("async_rst_addr", imemaddr, 32'h0);
    m_cnt = 0; m_pc = 32'h0; m_halted = 0;
    sb_q.delete();
  endtask

  // Monitor: compares status every stepped cycle and pops the scoreboard
  // whenever the DUT hands out its head entry.
  initial begin
    forever begin
      @(negedge CLK);
      #2;
      if (exp_fresh) begin
        exp_fresh = 0;
        check("count", 32'(count), 32'(exp_count));
        check("valid", 32'(valid), 32'(exp_count != 0));
        check("imemREN", 32'(imemREN), 32'(exp_ren));
        check("imemaddr", imemaddr, exp_addr);
        check("halted", 32'(halted), 32'(exp_halted));
        if (valid) begin
          if (sb_q.size() == 0) begin
            check("head_present", 32'(valid), 32'd0);
          end else begin
            check("instr", instr, sb_q[0].word);
            check("instr_pc", instr_pc, sb_q[0].pc);
            if (deq && !redirect) void'(sb_q.pop_front());
          end
        end else begin
          check("instr_nop", instr, 32'h0);
          check("instr_pc_zero", instr_pc, 32'h0);
        end
        if (redirect) sb_q.delete();
      end
    end
  end

  initial begin
    // Reset values while nRST is held low.
    #12;
    check("rst_addr", imemaddr, 32'h0);
    check("rst_ren", 32'(imemREN), 32'd1);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_wrap_addr", imemaddr2, 32'hFFFF_FFFC);

    // PC wrap on the second instance, then deq on empty.
    step(0, '0, 0, 0, '0, 0);
    ihit2 = 1'b1; imemload2 = 32'h55;
    step(0, '0, 0, 0, '0, 0);
    ihit2 = 1'b0;
    #1;
    check("wrap_valid", 32'(valid2), 32'd1);
    check("wrap_instr", instr2, 32'h55);
    check("wrap_instr_pc", instr_pc2, 32'hFFFF_FFFC);
    check("wrap_addr", imemaddr2, 32'h0);
    deq2 = 1'b1;
    step(0, '0, 0, 0, '0, 0);
    step(0, '0, 0, 0, '0, 0);
    deq2 = 1'b0;
    #1;
    check("wrap_empty_count", 32'(count2), 32'd0);

    // Fill to full; further ihit ignored.
    for (int i = 0; i < 4; i++) step(1, 32'hA0 + 32'(i), 0, 0, '0, 0);
    step(1, 32'hEE, 0, 0, '0, 0);
    step(1, 32'hEF, 0, 0, '0, 0);
    #1;
    check("full_count", 32'(count), 32'd4);
    check("full_ren", 32'(imemREN), 32'd0);
    check("full_addr", imemaddr, 32'h10);
    check("full_head", instr, 32'hA0);
    check("full_head_pc", instr_pc, 32'h0);

    // Simultaneous push/pop at count 2.
    step(0, '0, 0, 1, 32'h0, 0);
    step(1, 32'hB0, 0, 0, '0, 0);
    step(1, 32'hB1, 0, 0, '0, 0);
    for (int i = 0; i < 3; i++) step(1, 32'hC0 + 32'(i), 1, 0, '0, 0);
    step(0, '0, 0, 0, '0, 0);
    #1;
    check("pushpop_count", 32'(count), 32'd2);
    check("pushpop_addr", imemaddr, 32'h14);

    // Redirect at count 3 with ihit and deq in the same cycle.
    step(1, 32'hC3, 0, 0, '0, 0);
    step(1, 32'hDEAD, 1, 1, 32'h403, 0);
    step(0, '0, 0, 0, '0, 0);
    #1;
    check("redir_count", 32'(count), 32'd0);
    check("redir_addr", imemaddr, 32'h400);
    check("redir_ren", 32'(imemREN), 32'd1);

    // Halt at count 2, then drain.
    step(1, 32'hE0, 0, 0, '0, 0);
    step(1, 32'hE1, 0, 0, '0, 0);
    step(0, '0, 0, 0, '0, 1);
    step(1, 32'hF0, 1, 0, '0, 0);
    step(1, 32'hF1, 1, 0, '0, 0);
    step(1, 32'hF2, 0, 0, '0, 0);
    #1;
    check("halt_flag", 32'(halted), 32'd1);
    check("halt_drained", 32'(count), 32'd0);
    check("halt_ren", 32'(imemREN), 32'd0);

    // Asynchronous reset mid-fill at count 3.
    async_reset();
    for (int i = 0; i < 3; i++) step(1, 32'h300 + 32'(i), 0, 0, '0, 0);
    async_reset();
    idle(2);

    // Randomized traffic in phases separated by resets.
    for (int ph = 0; ph < 6; ph++) begin
      for (int i = 0; i < 400; i++) begin
        step($urandom_range(0, 3) != 0, $urandom(),
             $urandom_range(0, 2) == 0 ? 1'b1 : ($urandom_range(0, 1) == 1),
             $urandom_range(0, 19) == 0, $urandom(),
             $urandom_range(0, 299) == 0);
      end
      async_reset();
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
Parametrised instruction-fetch front end for the next-generation datapath. It owns the fetch PC, issues instruction-memory reads through the datapath/cache handshake (imemREN/imemaddr/ihit/imemload), and buffers returned words with their PCs in a DEPTH-entry FIFO. Decode therefore no longer stalls on every ihit. Branch/jump redirects from execute flush the queue; a halt stops fetch while already-buffered instructions drain.

Parameters:
PC_INIT, 32'h0, fetch PC value after reset.
WORD_W, 32, instruction and PC width.
DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
CLK  in  1  clock; all state updates on the rising edge.
nRST  in  1  asynchronous active-low reset.
ihit  in  1  instruction memory returns valid data for imemaddr this cycle.
imemload  in  WORD_W  instruction word; valid only when ihit=1.
imemREN  out  1  instruction read request.
imemaddr  out  WORD_W  address being fetched; always equals fetch_pc.
redirect  in  1  flush the queue and restart fetch at redirect_pc.
redirect_pc  in  WORD_W  new fetch address.
halt  in  1  stop fetching; sticky.
deq  in  1  consumer takes the head entry this cycle.
valid  out  1  head entry present (count != 0).
instr  out  WORD_W  head instruction; 0 (nop) when valid=0.
instr_pc  out  WORD_W  PC of the head instruction; 0 when valid=0.
count  out  $clog2(DEPTH+1)  occupancy, 0..DEPTH.
halted  out  1  halt has been latched.

Behaviour:
- Reset (nRST=0, asynchronous): fetch_pc=PC_INIT, rd_ptr=wr_ptr=0, count=0, halted=0. Outputs: valid=0, instr=0, instr_pc=0, imemREN=1 (unless DEPTH config invalid), imemaddr=PC_INIT. Reset asserted mid-operation discards every entry immediately, with no wait for the clock.
- imemREN = !halted && !redirect && (count < DEPTH). This is combinational. A pending deq does not re-enable the request when the queue is full.
- push = imemREN && ihit. On push, the entry {imemload, fetch_pc} is written at wr_ptr, wr_ptr advances mod DEPTH, and fetch_pc <= fetch_pc + 4, wrapping modulo 2^WORD_W. ihit while imemREN=0 is ignored.
- pop = deq && valid. On pop, rd_ptr advances mod DEPTH. deq while empty is ignored: no underflow, count stays 0.
- Push and pop in the same cycle: count unchanged, both pointers advance. Latency is one cycle: a word pushed into an empty queue appears on instr/valid the next cycle; there is no same-cycle bypass.
- redirect=1 has priority over everything except reset:
  - rd_ptr=wr_ptr=0 and count=0 next cycle.
  - fetch_pc <= {redirect_pc[WORD_W-1:2], 2'b00}; the low two bits are forced to zero.
  - ihit and deq in that cycle are discarded.
  - Redirect while halted still flushes and loads fetch_pc; halted stays 1.
- halt=1 sampled at an edge sets halted=1 until reset. imemREN drops the next cycle. Queue contents remain and drain via deq. halt and redirect in the same cycle apply both effects.
- halt and push in the same cycle: the push completes, and that word is kept.
- instr/instr_pc come directly from the head register-array entry (registered storage, no combinational path from imemload).
- count is updated from push/pop/redirect only; it never exceeds DEPTH.

Test Plan:
1. Reset, DEPTH=4, PC_INIT=0 -> imemaddr=0x0, imemREN=1, valid=0, count=0, instr=0. Assert nRST low mid-fill at count=3 -> count=0, valid=0 immediately, with no clock edge.
2. ihit=1 every cycle, imemload=0xA0..0xA3, deq=0 -> after 4 edges count=4, imemREN=0, imemaddr=0x10. Further ihit has no effect. Head instr=0xA0, instr_pc=0x0.
3. At count=2, assert ihit=1 and deq=1 together for 3 cycles -> count stays 2. instr_pc sequence 0x0, 0x4, 0x8. imemaddr advances by 4 each cycle.
4. At count=3, assert redirect=1, redirect_pc=0x403, ihit=1, deq=1 -> next cycle count=0, valid=0, imemaddr=0x400, imemREN=1. The word returned with that ihit never appears on instr.
5. At count=2, assert halt=1 for 1 cycle -> halted=1 and imemREN=0 thereafter. Two deq cycles drain the entries in order, then valid=0. Further ihit is ignored.
6. PC_INIT=0xFFFFFFFC, one ihit -> entry instr_pc=0xFFFFFFFC, imemaddr wraps to 0x0. deq on an empty queue -> count stays 0.
